board_cursor_ctrl: RTL and testbench
====================================

BOARD_CURSOR_CTRL -- requirements
Module: board_cursor_ctrl

Interface
REQ-001 Parameter BOARD_N, default 8, cells per board side (2..16); CW = clog2(BOARD_N).
REQ-002 Parameter CELL_PITCH, default 13, pixel pitch between adjacent cells.
REQ-003 Parameter X_ORIGIN, default 9, pixel x of cell column 0.
REQ-004 Parameter Y_ORIGIN, default 9, pixel y of cell row 0.
REQ-005 clock  input  1  single clock, all state on rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 move_up, move_down, move_left, move_right  input  1 each  level-held direction requests.
REQ-008 turn_side  input  1  level-held side-toggle request.
REQ-009 place_disk  input  1  level-held disk-placement request.
REQ-010 plot_ack  input  1  drawer pulse: the current plot request is complete.
REQ-011 x, y  output  CW each  cursor cell column and row.
REQ-012 x_plot  output  8  pixel x of the plot target; y_plot  output  7  pixel y of the plot target.
REQ-013 select  output  2  drawer mode: 0 erase, 1 box, 2 disk side 0, 3 disk side 1.
REQ-014 plot_req  output  1  registered request, valid with x_plot/y_plot/select.
REQ-015 side  output  1  current player; busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 Each of the six level inputs is rising-edge detected internally; a held level produces exactly one event.
REQ-017 The FSM has four states: IDLE, ERASE, BOX and DISK; plot_req is high in ERASE, BOX and DISK and low in IDLE.
REQ-018 In IDLE, events have the following priority: place_disk, then up, then down, then left, then right; only one event is accepted per cycle.
REQ-019 Move and disk events arriving outside IDLE are discarded, not queued.
REQ-020 An accepted move latches the old cell, updates x/y, and goes IDLE->ERASE (select 0, old-cell pixels), then on plot_ack ->BOX (select 1, new-cell pixels), then on plot_ack ->IDLE.
REQ-021 An accepted place_disk goes IDLE->DISK (select {1,side}, current-cell pixels), then on plot_ack ->IDLE; position is unchanged.
REQ-022 Pixel coordinates are x_plot = X_ORIGIN + x*CELL_PITCH and y_plot = Y_ORIGIN + y*CELL_PITCH, truncated to 8 and 7 bits, registered when the state is entered.
REQ-023 x_plot, y_plot and select hold stable while plot_req is high; a plot_ack seen in IDLE is ignored.
REQ-024 A turn_side event toggles side in any state, the same cycle as any other event; DISK latches side at entry.
REQ-025 A move that would leave the 0..BOARD_N-1 range is handled per REQ-029/030.

Reset
REQ-026 While resetn is low: x=0, y=0, side=0, state IDLE, plot_req=0, select=0, x_plot=X_ORIGIN, y_plot=Y_ORIGIN, and the edge-detector history is cleared.
REQ-027 Reset asserted mid-sequence aborts the sequence with no further plot_req; a level input held through reset release does not generate an event.
REQ-028 An input rising on the first cycle after release is accepted.

Configuration
REQ-029 With CURSOR_WRAP_EN defined, an out-of-range move wraps: 0-1 becomes BOARD_N-1, and BOARD_N-1+1 becomes 0; the ERASE/BOX sequence runs as normal.
REQ-030 Without CURSOR_WRAP_EN, an out-of-range move is blocked: position is unchanged, no plot sequence runs, and the FSM stays in IDLE.

Verification (defaults)
REQ-031 Reset, pulse move_right, ack each request -> ERASE at (9,9) select 0, then BOX at (22,9) select 1, x=1, then IDLE.
REQ-032 move_left at x=0 -> without wrap: no plot_req, x=0; with wrap: x=7, ERASE at (9,9), BOX at (100,9).
REQ-033 Hold move_down for 20 cycles with immediate acks -> y=1 exactly, exactly two plot requests.
REQ-034 Pulse turn_side then place_disk at (3,2) -> side=1, DISK at (48,35) select 3.
REQ-035 Pulse move_up while in BOX before ack -> move discarded, y unchanged after the sequence completes.
REQ-036 Assert resetn low during ERASE -> plot_req=0 immediately; all outputs at REQ-026 values; no request after release.

Source files
------------

// File: rtl/board_cursor_ctrl.sv
// Board cursor controller: edge-detected move/side/disk requests drive an erase/box/disk plot handshake.
// Define CURSOR_WRAP_EN to wrap the cursor at board edges; otherwise out-of-range moves are blocked.
//   state | meaning
//   IDLE  | waiting for an input event, no plot pending
//   ERASE | erase box at the cell the cursor just left
//   BOX   | draw box at the new cursor cell
//   DISK  | draw a disk of the latched side at the cursor cell
module board_cursor_ctrl #(
  parameter int BOARD_N    = 8,
  parameter int CELL_PITCH = 13,
  parameter int X_ORIGIN   = 9,
  parameter int Y_ORIGIN   = 9,
  localparam int CW        = $clog2(BOARD_N)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          move_up,
  input  logic          move_down,
  input  logic          move_left,
  input  logic          move_right,
  input  logic          turn_side,
  input  logic          place_disk,
  input  logic          plot_ack,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [7:0]    x_plot,
  output logic [6:0]    y_plot,
  output logic [1:0]    select,
  output logic          plot_req,
  output logic          side,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ERASE, BOX, DISK} state_t;

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [CW-1:0] MAX = CW'(BOARD_N - 1);

  state_t        state, state_next;
  logic [5:0]    lvl, hist, ev;
  logic          ev_right, ev_left, ev_down, ev_up, ev_turn, ev_disk;
  logic [CW-1:0] x_next, y_next, tx, ty;
  logic          mv_ok;
  logic [7:0]    x_plot_next;
  logic [6:0]    y_plot_next;
  logic [1:0]    select_next;

  function automatic logic [7:0] pix_x(input logic [CW-1:0] c);
    return 8'(X_ORIGIN + 32'(c) * CELL_PITCH);
  endfunction

  function automatic logic [6:0] pix_y(input logic [CW-1:0] r);
    return 7'(Y_ORIGIN + 32'(r) * CELL_PITCH);
  endfunction

  assign lvl = {place_disk, turn_side, move_up, move_down, move_left, move_right};
  assign ev  = lvl & ~hist;
  assign {ev_disk, ev_turn, ev_up, ev_down, ev_left, ev_right} = ev;

  // History resets to "held" so a level asserted through reset release yields no event.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) hist <= '1;
    else         hist <= lvl;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    x_next      = x;
    y_next      = y;
    x_plot_next = x_plot;
    y_plot_next = y_plot;
    select_next = select;
    tx          = x;
    ty          = y;
    mv_ok       = 1'b1;
    if (ev_up) begin
      if (y == '0) begin ty = MAX; mv_ok = WRAP; end
      else ty = y - CW'(1);
    end else if (ev_down) begin
      if (y == MAX) begin ty = '0; mv_ok = WRAP; end
      else ty = y + CW'(1);
    end else if (ev_left) begin
      if (x == '0) begin tx = MAX; mv_ok = WRAP; end
      else tx = x - CW'(1);
    end else if (ev_right) begin
      if (x == MAX) begin tx = '0; mv_ok = WRAP; end
      else tx = x + CW'(1);
    end
    case (state)
      IDLE: begin
        if (ev_disk) begin
          state_next  = DISK;
          select_next = {1'b1, side};
          x_plot_next = pix_x(x);
          y_plot_next = pix_y(y);
        end else if ((ev_up | ev_down | ev_left | ev_right) && mv_ok) begin
          state_next  = ERASE;
          x_next      = tx;
          y_next      = ty;
          select_next = 2'd0;
          x_plot_next = pix_x(x);
          y_plot_next = pix_y(y);
        end
      end
      ERASE: begin
        if (plot_ack) begin
          state_next  = BOX;
          select_next = 2'd1;
          x_plot_next = pix_x(x);
          y_plot_next = pix_y(y);
        end
      end
      BOX:     if (plot_ack) state_next = IDLE;
      DISK:    if (plot_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x        <= '0;
      y        <= '0;
      side     <= 1'b0;
      select   <= 2'd0;
      x_plot   <= 8'(X_ORIGIN);
      y_plot   <= 7'(Y_ORIGIN);
      plot_req <= 1'b0;
    end else begin
      x        <= x_next;
      y        <= y_next;
      select   <= select_next;
      x_plot   <= x_plot_next;
      y_plot   <= y_plot_next;
      plot_req <= (state_next != IDLE);
      if (ev_turn) side <= ~side;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Directed bench for board_cursor_ctrl at default parameters; honours CURSOR_WRAP_EN when defined.
module tb_board_cursor_ctrl;
  logic       clock = 1'b0;
  logic       resetn;
  logic       move_up, move_down, move_left, move_right;
  logic       turn_side, place_disk, plot_ack;
  logic [2:0] x, y;
  logic [7:0] x_plot;
  logic [6:0] y_plot;
  logic [1:0] select;
  logic       plot_req, side, busy;

  int n_assert = 0;
  int n_fail   = 0;
  int nreq;

  board_cursor_ctrl dut (
    .clock(clock), .resetn(resetn),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .turn_side(turn_side), .place_disk(place_disk), .plot_ack(plot_ack),
    .x(x), .y(y), .x_plot(x_plot), .y_plot(y_plot), .select(select),
    .plot_req(plot_req), .side(side), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_side"}, 32'(side), 0);
    chk({tag, "_req"}, 32'(plot_req), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_sel"}, 32'(select), 0);
    chk({tag, "_xp"}, 32'(x_plot), 9);
    chk({tag, "_yp"}, 32'(y_plot), 9);
  endtask

  // dir: 0 up, 1 down, 2 left, 3 right; one pulse then two acks
  task automatic move_seq(input int dir);
    case (dir)
      0: move_up = 1'b1;
      1: move_down = 1'b1;
      2: move_left = 1'b1;
      default: move_right = 1'b1;
    endcase
    cyc(1);
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
    plot_ack = 1'b1;
    cyc(2);
    plot_ack = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
    turn_side = 1'b0; place_disk = 1'b0; plot_ack = 1'b0;
    cyc(2);
    check_reset_values("rst");
    resetn = 1'b1;
    cyc(2);

    // single move right with handshake
    move_right = 1'b1;
    cyc(1);
    move_right = 1'b0;
    chk("mr_erase_req", 32'(plot_req), 1);
    chk("mr_erase_sel", 32'(select), 0);
    chk("mr_erase_xp", 32'(x_plot), 9);
    chk("mr_erase_yp", 32'(y_plot), 9);
    chk("mr_x", 32'(x), 1);
    chk("mr_busy", 32'(busy), 1);
    cyc(2);
    chk("mr_hold_xp", 32'(x_plot), 9);
    chk("ignore_no_ack", 32'(select), 0);
    plot_ack = 1'b1;
    cyc(1);
    plot_ack = 1'b0;
    chk("mr_box_req", 32'(plot_req), 1);
    chk("mr_box_sel", 32'(select), 1);
    chk("mr_box_xp", 32'(x_plot), 22);
    chk("mr_box_yp", 32'(y_plot), 9);
    plot_ack = 1'b1;
    cyc(1);
    plot_ack = 1'b0;
    chk("mr_idle_req", 32'(plot_req), 0);
    chk("mr_idle_busy", 32'(busy), 0);

    // back to column 0, then push past the left edge
    move_seq(2);
    chk("ml_x0", 32'(x), 0);
    move_left = 1'b1;
    cyc(1);
    move_left = 1'b0;
`ifdef CURSOR_WRAP_EN
    chk("wrap_req", 32'(plot_req), 1);
    chk("wrap_x", 32'(x), 7);
    chk("wrap_erase_xp", 32'(x_plot), 9);
    plot_ack = 1'b1;
    cyc(1);
    chk("wrap_box_xp", 32'(x_plot), 100);
    chk("wrap_box_sel", 32'(select), 1);
    cyc(1);
    plot_ack = 1'b0;
    move_seq(3);
    chk("wrap_right_x", 32'(x), 0);
`else
    chk("block_req", 32'(plot_req), 0);
    chk("block_x", 32'(x), 0);
    cyc(2);
    chk("block_busy", 32'(busy), 0);
`endif

    // held move_down with continuous ack
    nreq = 0;
    move_down = 1'b1;
    plot_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (plot_req) nreq++;
    end
    move_down = 1'b0;
    plot_ack = 1'b0;
    chk("hold_nreq", 32'(nreq), 2);
    chk("hold_y", 32'(y), 1);

    // walk to (3,2), toggle side, place a disk
    move_seq(3);
    move_seq(3);
    move_seq(3);
    move_seq(1);
    chk("pos_x3", 32'(x), 3);
    chk("pos_y2", 32'(y), 2);
    turn_side = 1'b1;
    cyc(1);
    turn_side = 1'b0;
    chk("turn_side", 32'(side), 1);
    chk("turn_no_req", 32'(plot_req), 0);
    place_disk = 1'b1;
    cyc(1);
    place_disk = 1'b0;
    chk("disk_req", 32'(plot_req), 1);
    chk("disk_sel", 32'(select), 3);
    chk("disk_xp", 32'(x_plot), 48);
    chk("disk_yp", 32'(y_plot), 35);
    plot_ack = 1'b1;
    cyc(1);
    plot_ack = 1'b0;
    chk("disk_done", 32'(plot_req), 0);
    chk("disk_x", 32'(x), 3);
    chk("disk_y", 32'(y), 2);

    // move_up while in BOX is discarded
    move_right = 1'b1;
    cyc(1);
    move_right = 1'b0;
    plot_ack = 1'b1;
    cyc(1);
    plot_ack = 1'b0;
    move_up = 1'b1;
    cyc(1);
    move_up = 1'b0;
    chk("box_hold_sel", 32'(select), 1);
    chk("box_hold_xp", 32'(x_plot), 61);
    plot_ack = 1'b1;
    cyc(1);
    plot_ack = 1'b0;
    cyc(2);
    chk("discard_req", 32'(plot_req), 0);
    chk("discard_y", 32'(y), 2);
    chk("discard_x", 32'(x), 4);

    // reset during ERASE
    move_left = 1'b1;
    cyc(1);
    move_left = 1'b0;
    chk("pre_rst_req", 32'(plot_req), 1);
    chk("pre_rst_xp", 32'(x_plot), 61);
    resetn = 1'b0;
    #1;
    check_reset_values("mid_rst");
    move_right = 1'b1;
    cyc(2);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("held_thru_rst", 32'(plot_req), 0);
    end
    chk("held_x", 32'(x), 0);
    move_right = 1'b0;

    // fresh rise just after release is accepted
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    cyc(1);
    move_down = 1'b1;
    cyc(1);
    move_down = 1'b0;
    chk("post_rst_req", 32'(plot_req), 1);
    chk("post_rst_y", 32'(y), 1);
    plot_ack = 1'b1;
    cyc(2);
    plot_ack = 1'b0;
    chk("post_rst_done", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
